// File: rtl/io_defs.sv
// Shared definitions for the interrupt controller: register map, status layout, reset vector.
package io_defs;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned IRQ_W     = 8;
    localparam int unsigned REG_COUNT = 4;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_VECTOR  = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [15:0] VEC_RST = 16'h0017;

    // Status register: in-service one-hot in the upper byte, active flag in bit 0.
    typedef struct packed {
        logic [7:0] id;
        logic [6:0] rsvd;
        logic       active;
    } status_t;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational lowest-bit-first one-hot priority encoder.
module int_prio_enc
    import io_defs::*;
(
    input  logic [IRQ_W-1:0] req,
    output logic [IRQ_W-1:0] grant_c
);

    // Two's-complement trick isolates the lowest set bit; zero input yields zero.
    assign grant_c = req & (~req + IRQ_W'(1));

endmodule

// File: rtl/int_ctrl.sv
// Edge-triggered 8-line interrupt controller with memory-mapped registers and CPU
// acknowledge / return-address handshake on a shared tristate data bus.
module int_ctrl #(
    parameter logic [15:0] BASE    = 16'hFF00,
    parameter logic [15:0] VEC_RST = io_defs::VEC_RST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] d_addr,
    inout  wire  [15:0] d_bus,
    input  logic        push_int_addr,
    input  logic        push_ints,
    input  logic        store_retaddr,
    input  logic        push_retaddr,
    output logic        interrupt
);
    import io_defs::*;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] SERVICE = 1'b1;

    logic [0:0]        state,    state_nxt;
    logic [IRQ_W-1:0]  mask,     mask_nxt;
    logic [DATA_W-1:0] vector,   vector_nxt;
    logic [IRQ_W-1:0]  pending,  pending_nxt;
    logic [DATA_W-1:0] retaddr,  retaddr_nxt;
    logic [IRQ_W-1:0]  isid,     isid_nxt;
    logic              interrupt_nxt;
    logic [IRQ_W-1:0]  irq_q;
    logic              edge_en;
    logic [DATA_W-1:0] rdata,    rdata_nxt;
    logic              rmatch;

    logic [DATA_W-1:0] offset;
    logic              hit;
    logic              wr;
    logic [1:0]        reg_sel;
    logic [IRQ_W-1:0]  edge_set;
    logic [IRQ_W-1:0]  w1c;
    logic [IRQ_W-1:0]  grant;
    status_t           status;
    logic              drive_en;
    logic [DATA_W-1:0] drive_data;

    assign offset  = d_addr - BASE;
    assign hit     = offset < DATA_W'(REG_COUNT);
    assign wr      = write & hit;
    assign reg_sel = offset[1:0];

    // The first cycle after reset only primes irq_q, so lines held high through reset stay quiet.
    assign edge_set = irq & ~irq_q & {IRQ_W{edge_en}};

    assign status.id     = isid;
    assign status.rsvd   = '0;
    assign status.active = (state == SERVICE);

    int_prio_enc u_prio (
        .req     (pending & mask),
        .grant_c (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            vector    <= VEC_RST;
            pending   <= '0;
            retaddr   <= '0;
            isid      <= '0;
            interrupt <= 1'b0;
            irq_q     <= '0;
            edge_en   <= 1'b0;
            rdata     <= '0;
            rmatch    <= 1'b0;
        end else begin
            state     <= state_nxt;
            mask      <= mask_nxt;
            vector    <= vector_nxt;
            pending   <= pending_nxt;
            retaddr   <= retaddr_nxt;
            isid      <= isid_nxt;
            interrupt <= interrupt_nxt;
            irq_q     <= irq;
            edge_en   <= 1'b1;
            rdata     <= rdata_nxt;
            rmatch    <= read & hit;
        end
    end

    // Next-state: register writes, ack/return handshake, pending set/clear, interrupt.
    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask;
        vector_nxt  = vector;
        retaddr_nxt = retaddr;
        isid_nxt    = isid;
        w1c         = '0;

        if (wr) begin
            case (reg_sel)
                REG_MASK:    mask_nxt   = d_bus[IRQ_W-1:0];
                REG_VECTOR:  vector_nxt = d_bus;
                REG_PENDING: w1c        = d_bus[IRQ_W-1:0];
                default:     ;
            endcase
        end

        if (store_retaddr) begin
            retaddr_nxt = d_bus;
        end

        case (state)
            IDLE: begin
                if (push_int_addr) begin
                    state_nxt = SERVICE;
                    isid_nxt  = grant;
                    w1c       = w1c | grant;
                end
            end
            SERVICE: begin
                if (push_retaddr) begin
                    state_nxt = IDLE;
                    isid_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A new edge beats any clear in the same cycle.
        pending_nxt   = (pending & ~w1c) | edge_set;
        interrupt_nxt = (|(pending_nxt & mask_nxt)) && (state_nxt == IDLE);
    end

    always_comb begin
        rdata_nxt = '0;
        case (reg_sel)
            REG_MASK:    rdata_nxt = {8'h00, mask};
            REG_VECTOR:  rdata_nxt = vector;
            REG_PENDING: rdata_nxt = {8'h00, pending};
            default:     rdata_nxt = status;
        endcase
    end

    // Bus drive; store_retaddr leaves the bus to the CPU.
    always_comb begin
        drive_en   = 1'b0;
        drive_data = '0;
        if (push_int_addr) begin
            drive_en   = 1'b1;
            drive_data = vector;
        end else if (store_retaddr) begin
            drive_en   = 1'b0;
        end else if (push_retaddr) begin
            drive_en   = 1'b1;
            drive_data = retaddr;
        end else if (push_ints) begin
            drive_en   = 1'b1;
            drive_data = {8'h00, isid};
        end else if (read && rmatch) begin
            drive_en   = 1'b1;
            drive_data = rdata;
        end
    end

    assign d_bus = drive_en ? drive_data : 'z;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: spec-level model checked every cycle plus directed literal checks.
module tb_int_ctrl;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq = 8'h00;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic        push_int_addr = 1'b0;
    logic        push_ints = 1'b0;
    logic        store_retaddr = 1'b0;
    logic        push_retaddr = 1'b0;
    logic        interrupt;
    logic        tb_en = 1'b0;
    logic [15:0] tb_drv = 16'h0000;
    wire  [15:0] d_bus;

    assign d_bus = tb_en ? tb_drv : 'z;

    int_ctrl #(.BASE(BASE), .VEC_RST(16'h0017)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq           (irq),
        .read          (read),
        .write         (write),
        .d_addr        (d_addr),
        .d_bus         (d_bus),
        .push_int_addr (push_int_addr),
        .push_ints     (push_ints),
        .store_retaddr (store_retaddr),
        .push_retaddr  (push_retaddr),
        .interrupt     (interrupt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_mask, m_pend, m_isid, m_prev;
    logic [15:0] m_vec, m_ret, m_rd_val;
    logic        m_busy, m_fresh, m_rd_ok, m_int;
    logic [7:0]  rise, gr, clr;
    logic        hit;
    int          off;

    function automatic logic [7:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 8'(1 << i);
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mask = 8'h00; m_vec = 16'h0017; m_pend = 8'h00; m_ret = 16'h0000;
            m_busy = 1'b0; m_isid = 8'h00; m_prev = 8'h00; m_fresh = 1'b1;
            m_int = 1'b0; m_rd_ok = 1'b0; m_rd_val = 16'h0000;
        end else begin
            rise = m_fresh ? 8'h00 : (irq & ~m_prev);
            gr   = lowest(m_pend & m_mask);
            off  = int'(d_addr) - int'(BASE);
            hit  = (off >= 0) && (off < 4);
            m_rd_ok = read && hit;
            if (hit) begin
                case (off)
                    0: m_rd_val = {8'h00, m_mask};
                    1: m_rd_val = m_vec;
                    2: m_rd_val = {8'h00, m_pend};
                    default: m_rd_val = {m_isid, 7'b0, m_busy};
                endcase
            end
            clr = 8'h00;
            if (write && hit) begin
                if (off == 0) m_mask = tb_drv[7:0];
                else if (off == 1) m_vec = tb_drv;
                else if (off == 2) clr = tb_drv[7:0];
            end
            if (store_retaddr) m_ret = tb_drv;
            if (push_int_addr && !m_busy) begin
                m_busy = 1'b1;
                m_isid = gr;
                clr = clr | gr;
            end else if (push_retaddr && m_busy) begin
                m_busy = 1'b0;
                m_isid = 8'h00;
            end
            m_pend  = (m_pend & ~clr) | rise;
            m_int   = (|(m_pend & m_mask)) && !m_busy;
            m_prev  = irq;
            m_fresh = 1'b0;
        end
    end

    task automatic exp_bus(output logic en, output logic [15:0] v);
        en = 1'b1;
        v  = 16'h0000;
        if (push_int_addr) v = m_vec;
        else if (tb_en) v = tb_drv;
        else if (store_retaddr) en = 1'b0;
        else if (push_retaddr) v = m_ret;
        else if (push_ints) v = {8'h00, m_isid};
        else if (read && m_rd_ok) v = m_rd_val;
        else en = 1'b0;
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        logic        e_en;
        logic [15:0] e_v;
        if (chk_en) begin
            check("model_interrupt", {15'b0, interrupt}, {15'b0, m_int});
            exp_bus(e_en, e_v);
            if (e_en) check("model_d_bus", d_bus, e_v);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int o, input logic [15:0] data);
        write = 1'b1; d_addr = BASE + 16'(o); tb_en = 1'b1; tb_drv = data;
        tick();
        write = 1'b0; tb_en = 1'b0;
    endtask

    task automatic rd(input int o, input logic [15:0] exp, input string name);
        read = 1'b1; d_addr = BASE + 16'(o);
        tick();
        @(negedge clk);
        check(name, d_bus, exp);
        tick();
        read = 1'b0;
    endtask

    task automatic chk_int(input logic exp, input string name);
        @(negedge clk);
        check(name, {15'b0, interrupt}, {15'b0, exp});
        tick();
    endtask

    task automatic chk_bus(input logic [15:0] exp, input string name);
        @(negedge clk);
        check(name, d_bus, exp);
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        chk_int(1'b0, "reset_interrupt");
        rd(0, 16'h0000, "reset_mask");
        rd(1, 16'h0017, "reset_vector");

        // Basic ack of irq[2]
        wr(0, 16'h0005);
        irq = 8'h04; tick(); irq = 8'h00;
        @(negedge clk); check("irq2_interrupt", {15'b0, interrupt}, 16'h0001);
        tick();
        push_int_addr = 1'b1;
        chk_bus(16'h0017, "ack_vector");
        tick(); push_int_addr = 1'b0;
        chk_int(1'b0, "ack_int_drops");
        rd(3, 16'h0401, "ack_status");

        // Return address round trip
        store_retaddr = 1'b1; tb_en = 1'b1; tb_drv = 16'h0123;
        tick(); store_retaddr = 1'b0; tb_en = 1'b0;
        push_retaddr = 1'b1;
        chk_bus(16'h0123, "retaddr_bus");
        tick(); push_retaddr = 1'b0;
        rd(3, 16'h0000, "ret_status");

        // Priority between simultaneous edges
        wr(0, 16'h00FF);
        irq = 8'h05; tick(); irq = 8'h00;
        push_int_addr = 1'b1; tick(); push_int_addr = 1'b0;
        rd(3, 16'h0101, "prio_status");
        rd(2, 16'h0004, "prio_pending");
        push_ints = 1'b1;
        chk_bus(16'h0001, "push_ints_id");
        tick(); push_ints = 1'b0;
        push_retaddr = 1'b1; tick(); push_retaddr = 1'b0;
        chk_int(1'b1, "reassert_after_ret");
        push_int_addr = 1'b1; tick(); push_int_addr = 1'b0;
        rd(3, 16'h0401, "second_ack_status");
        push_retaddr = 1'b1; tick(); push_retaddr = 1'b0;

        // Masking and W1C-vs-edge race
        wr(0, 16'h0000);
        irq = 8'h08; tick(); irq = 8'h00;
        chk_int(1'b0, "masked_int");
        rd(2, 16'h0008, "masked_pending");
        wr(0, 16'h0008);
        chk_int(1'b1, "unmask_int");
        irq = 8'h08; write = 1'b1; d_addr = BASE + 16'd2; tb_en = 1'b1; tb_drv = 16'h0008;
        tick();
        irq = 8'h00; write = 1'b0; tb_en = 1'b0;
        rd(2, 16'h0008, "set_beats_w1c");
        wr(2, 16'h0008);
        rd(2, 16'h0000, "w1c_clears");

        // Spurious ack
        wr(1, 16'hBEEF);
        rd(1, 16'hBEEF, "vector_rw");
        push_int_addr = 1'b1;
        chk_bus(16'hBEEF, "spurious_vector");
        tick(); push_int_addr = 1'b0;
        rd(3, 16'h0001, "spurious_status");
        push_ints = 1'b1;
        chk_bus(16'h0000, "spurious_ints");
        tick(); push_ints = 1'b0;

        // Reset during service with irq held high
        irq = 8'hFF; rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk_int(1'b0, "held_irq_int");
        rd(2, 16'h0000, "held_irq_pending");
        rd(3, 16'h0000, "reset_abandons_service");
        rd(1, 16'h0017, "vector_after_reset");
        irq = 8'h00; tick();
        irq = 8'h01; tick(); irq = 8'h00;
        rd(2, 16'h0001, "edge_after_reset");
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
